axi_node_w_router: RTL
======================

AXI_NODE_W_ROUTER -- requirements
Module: axi_node_w_router

Interface
REQ-001 SHALL have parameter N_MASTER, default 2, number of W input ports (>=1).
REQ-002 SHALL have parameter ID_WIDTH, default 4, AW ID width (>=1).
REQ-003 SHALL have parameter AUX_WIDTH, default 8, AW auxiliary payload width (>=1).
REQ-004 SHALL have parameter DATA_WIDTH, default 64, W data width (multiple of 8).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, outstanding-AW depth (power of two, >=2); SEL_WIDTH = max(1, clog2(N_MASTER)).
REQ-006 SHALL have ports, with one clock and a synchronous active-high reset:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous active-high reset
- aw_valid_i  in  1  arbitrated AW valid
- aw_ready_o  out  1  arbitrated AW ready
- aw_sel_i  in  SEL_WIDTH  index of the master granted the AW
- aw_id_i  in  ID_WIDTH  arbitrated AW ID
- aw_aux_i  in  AUX_WIDTH  arbitrated AW payload
- oup_aw_valid_o  out  1  AW valid to slave
- oup_aw_ready_i  in  1  AW ready from slave
- oup_aw_id_o  out  ID_WIDTH  AW ID to slave
- oup_aw_aux_o  out  AUX_WIDTH  AW payload to slave
- inp_wdata_i  in  N_MASTER x DATA_WIDTH  per-master W data
- inp_wstrb_i  in  N_MASTER x DATA_WIDTH/8  per-master W strobe
- inp_wlast_i  in  N_MASTER  per-master W last
- inp_wvalid_i  in  N_MASTER  per-master W valid
- inp_wready_o  out  N_MASTER  per-master W ready
- oup_wdata_o, oup_wstrb_o, oup_wlast_o, oup_wvalid_o  out  DATA_WIDTH, DATA_WIDTH/8, 1, 1  W to slave
- oup_wready_i  in  1  W ready from slave

Function
REQ-007 SHALL pass AW combinationally: oup_aw_valid_o = aw_valid_i & !full; aw_ready_o = oup_aw_ready_i & !full; id/aux forwarded unchanged.
REQ-008 SHALL push aw_sel_i into the select FIFO on the cycle aw_valid_i & aw_ready_o is high.
REQ-009 SHALL, while the FIFO is non-empty, route master head_sel to the output: oup_w* = inp_w*[head_sel], inp_wready_o[head_sel] = oup_wready_i, all other inp_wready_o bits 0.
REQ-010 SHALL, while the FIFO is empty, hold oup_wvalid_o = 0 and inp_wready_o = 0; W never precedes its AW handshake (minimum 1 cycle AW-to-W latency, no bypass).
REQ-011 SHALL pop the FIFO on the cycle oup_wvalid_o & oup_wready_i & oup_wlast_o is high; the next head is routed on the following cycle.
REQ-012 SHALL support simultaneous push and pop in one cycle, occupancy unchanged, including when full (pop frees a slot that is not reused in the same cycle: aw_ready_o remains 0 when full).
REQ-013 SHALL maintain occupancy count 0..FIFO_DEPTH; full = (count == FIFO_DEPTH), empty = (count == 0); read/write pointers wrap modulo FIFO_DEPTH.
REQ-014 SHALL treat aw_sel_i >= N_MASTER as a fatal simulation assertion; no RTL recovery.
REQ-015 SHALL keep output W signals stable while oup_wvalid_o & !oup_wready_i, given stable selected master inputs.

Reset
REQ-016 SHALL, on rst_i high at a clock edge, clear count and pointers to 0 (empty, not full), discarding any outstanding selections, including mid-burst.
REQ-017 SHALL, whenever rst_i is high, drive aw_ready_o, oup_aw_valid_o, oup_wvalid_o and all inp_wready_o to 0.

Structure
REQ-018 SHALL take the SEL_WIDTH derivation function and the W beat struct (data, strb, last) from the shared package axi_node_pkg.
REQ-019 SHALL implement the select FIFO as sub-module axi_node_sel_fifo (params WIDTH, DEPTH; push/pop/full/empty/head), instantiated once.

Verification
REQ-020 Single burst: AW sel=1, then 4 W beats on master 1 with wlast on beat 4 -> 4 beats out in order, FIFO empty after beat 4, master 0 wready stays 0.
REQ-021 Ordering: AWs sel=0, 1, 0 back-to-back; all masters present 2-beat bursts -> output beats strictly M0, M1, M0 bursts, 6 beats total.
REQ-022 Full: 4 AWs with no W traffic (FIFO_DEPTH=4) -> 5th AW sees aw_ready_o=0 and oup_aw_valid_o=0 until a wlast handshake, then accepted next cycle.
REQ-023 Simultaneous: full FIFO, AW valid and last beat accepted same cycle -> AW not accepted that cycle, accepted the next; count ends at 4.
REQ-024 Backpressure: oup_wready_i=0 for 3 cycles mid-burst -> oup_w* held stable, no beat lost or duplicated.
REQ-025 Reset mid-burst: rst_i asserted after beat 2 of 4 -> all ready/valid outputs 0 during reset, FIFO empty after, no W routed until a new AW.

Source files
------------

// File: rtl/axi_node_pkg.sv
// Shared AXI node types: W beat container and select-width derivation.
package axi_node_pkg;

  // Upper bound on W data width carried by the shared beat struct; routers
  // use the low DATA_WIDTH bits.
  localparam int unsigned W_DATA_MAX = 1024;

  typedef struct packed {
    logic [W_DATA_MAX-1:0]   data;
    logic [W_DATA_MAX/8-1:0] strb;
    logic                    last;
  } w_beat_t;

  // Width of a master index; a single master still needs one select bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axi_node_sel_fifo.sv
// Outstanding-AW select FIFO: holds the granted master index per accepted AW.
module axi_node_sel_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned PW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == CW'(DEPTH));
  assign empty_o = (r_count == '0);
  assign head_o  = r_mem[r_rptr];
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are qualified by the count so need no reset.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

endmodule

// File: rtl/axi_node_w_router.sv
// W channel router: AW handshakes record the granted master; W bursts are
// then routed from that master in AW order, one burst per recorded entry.
module axi_node_w_router
  import axi_node_pkg::*;
#(
  parameter int unsigned N_MASTER   = 2,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned AUX_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned SEL_WIDTH  = sel_width(N_MASTER),
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           aw_valid_i,
  output logic                           aw_ready_o,
  input  logic [SEL_WIDTH-1:0]           aw_sel_i,
  input  logic [ID_WIDTH-1:0]            aw_id_i,
  input  logic [AUX_WIDTH-1:0]           aw_aux_i,
  output logic                           oup_aw_valid_o,
  input  logic                           oup_aw_ready_i,
  output logic [ID_WIDTH-1:0]            oup_aw_id_o,
  output logic [AUX_WIDTH-1:0]           oup_aw_aux_o,
  input  logic [N_MASTER*DATA_WIDTH-1:0] inp_wdata_i,
  input  logic [N_MASTER*STRB_WIDTH-1:0] inp_wstrb_i,
  input  logic [N_MASTER-1:0]            inp_wlast_i,
  input  logic [N_MASTER-1:0]            inp_wvalid_i,
  output logic [N_MASTER-1:0]            inp_wready_o,
  output logic [DATA_WIDTH-1:0]          oup_wdata_o,
  output logic [STRB_WIDTH-1:0]          oup_wstrb_o,
  output logic                           oup_wlast_o,
  output logic                           oup_wvalid_o,
  input  logic                           oup_wready_i
);

  logic                 w_full;
  logic                 w_empty;
  logic [SEL_WIDTH-1:0] w_head;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_route;
  logic                 w_sel_valid;
  w_beat_t              w_beat;

  assign oup_aw_valid_o = ~rst_i & aw_valid_i & ~w_full;
  assign aw_ready_o     = ~rst_i & oup_aw_ready_i & ~w_full;
  assign oup_aw_id_o    = aw_id_i;
  assign oup_aw_aux_o   = aw_aux_i;

  assign w_push  = aw_valid_i & aw_ready_o;
  assign w_route = ~rst_i & ~w_empty;
  assign w_pop   = oup_wvalid_o & oup_wready_i & oup_wlast_o;

  axi_node_sel_fifo #(
    .WIDTH (SEL_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_sel_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .data_i  (aw_sel_i),
    .pop_i   (w_pop),
    .full_o  (w_full),
    .empty_o (w_empty),
    .head_o  (w_head)
  );

  // Mux the head master's W beat to the output and return ready to it only.
  always_comb begin
    w_beat       = '0;
    w_sel_valid  = 1'b0;
    inp_wready_o = '0;
    for (int unsigned m = 0; m < N_MASTER; m++) begin
      if (w_head == SEL_WIDTH'(m)) begin
        w_beat.data[DATA_WIDTH-1:0] = inp_wdata_i[m*DATA_WIDTH +: DATA_WIDTH];
        w_beat.strb[STRB_WIDTH-1:0] = inp_wstrb_i[m*STRB_WIDTH +: STRB_WIDTH];
        w_beat.last                 = inp_wlast_i[m];
        w_sel_valid                 = inp_wvalid_i[m];
        inp_wready_o[m]             = w_route & oup_wready_i;
      end
    end
    oup_wvalid_o = w_route & w_sel_valid;
    oup_wdata_o  = w_route ? w_beat.data[DATA_WIDTH-1:0] : '0;
    oup_wstrb_o  = w_route ? w_beat.strb[STRB_WIDTH-1:0] : '0;
    oup_wlast_o  = w_route & w_beat.last;
  end

  // An out-of-range master index is a fabric bug with no recovery path.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_push) begin
      assert (int'(aw_sel_i) < int'(N_MASTER))
        else $fatal(1, "aw_sel_i out of range");
    end
  end

endmodule
